// File: rtl/icache_nway_lookup_s1_pkg.sv
// I-cache stage-1 shared defaults and FSM state codes.
// Geometry defaults are overridable per instance.
package icache_nway_lookup_s1_pkg;

  localparam int ICACHE_WAYS       = 2;
  localparam int ICACHE_SETS       = 64;
  localparam int ICACHE_LINE_WORDS = 8;
  localparam int ICACHE_ADDR_W     = 32;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ic_state_e;

endpackage

// File: rtl/icache_way_ram.sv
// One I-cache way: tag RAM, per-word data banks, valid flops.
// Sync read with same-cycle write/clear forwarding into the read port.
module icache_way_ram #(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 8,
  parameter int TAG_W      = 21,
  parameter int IDX_W      = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [IDX_W-1:0]        rd_idx,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [TAG_W-1:0]        wr_tag,
  input  logic [LINE_WORDS*32-1:0] wr_line,
  input  logic                    clr_en,
  input  logic [IDX_W-1:0]        clr_idx,
  input  logic [IDX_W-1:0]        vld_idx,
  output logic                    vld_o,
  output logic [TAG_W-1:0]        rd_tag_o,
  output logic                    rd_valid_o,
  output logic [LINE_WORDS*32-1:0] rd_line_o
);

  logic [TAG_W-1:0] tag_mem [SETS];
  logic [SETS-1:0]  valid_q;
  logic             wr_hit;
  logic             clr_hit;

  assign wr_hit  = wr_en && (wr_idx == rd_idx);
  assign clr_hit = clr_en && (clr_idx == rd_idx);
  assign vld_o   = valid_q[vld_idx];

  always_ff @(posedge clk) begin
    if (wr_en) tag_mem[wr_idx] <= wr_tag;
  end

  // clear is issued after set so a same-set clear wins
  always_ff @(posedge clk) begin
    if (wr_en)  valid_q[wr_idx]  <= 1'b1;
    if (clr_en) valid_q[clr_idx] <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_tag_o   <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_tag_o   <= wr_hit ? wr_tag : tag_mem[rd_idx];
      rd_valid_o <= !clr_hit && (wr_hit || valid_q[rd_idx]);
    end
  end

  for (genvar b = 0; b < LINE_WORDS; b++) begin : g_bank
    logic [31:0] mem [SETS];
    logic [31:0] q;

    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_line[b*32 +: 32];
    end

    always_ff @(posedge clk) begin
      if (!rst_n)      q <= '0;
      else if (wr_hit) q <= wr_line[b*32 +: 32];
      else             q <= mem[rd_idx];
    end

    assign rd_line_o[b*32 +: 32] = q;
  end

endmodule

// File: rtl/icache_nway_lookup_s1.sv
// I-cache stage 1: RAM indexing, refill install, tree-PLRU,
// post-reset valid sweep and per-set invalidate; registers into S2.
module icache_nway_lookup_s1
  import icache_nway_lookup_s1_pkg::*;
#(
  parameter int WAYS       = ICACHE_WAYS,
  parameter int SETS       = ICACHE_SETS,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int ADDR_W     = ICACHE_ADDR_W,
  localparam int IDX_W     = $clog2(SETS),
  localparam int OFF_W     = $clog2(LINE_WORDS) + 2,
  localparam int TAG_W     = ADDR_W - IDX_W - OFF_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_i,
  input  logic                     cached_i,
  input  logic [ADDR_W-1:0]        vaddr_i,
  input  logic [ADDR_W-1:0]        paddr_i,
  input  logic                     stall_i,
  input  logic [WAYS-1:0]          hit_i,
  input  logic                     hit_valid_i,
  input  logic                     rfl_valid_i,
  input  logic [ADDR_W-1:0]        rfl_vaddr_i,
  input  logic [ADDR_W-1:0]        rfl_paddr_i,
  input  logic [LINE_WORDS*32-1:0] rfl_line_i,
  input  logic                     inv_valid_i,
  input  logic [IDX_W-1:0]         inv_index_i,
  output logic                     init_busy_o,
  output logic [ADDR_W-1:0]        s2_vaddr_o,
  output logic [ADDR_W-1:0]        s2_paddr_o,
  output logic                     s2_en_o,
  output logic                     s2_rreq_o,
  output logic                     s2_cached_o,
  output logic [WAYS*TAG_W-1:0]    s2_tag_o,
  output logic [WAYS-1:0]          s2_valid_o,
  output logic [WAYS*32-1:0]       s2_data_o,
  output logic [WAYS-1:0]          s2_victim_o,
  output logic                     s2_install_o
);

  localparam int WOFF_W = $clog2(LINE_WORDS);
  localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

  ic_state_e        state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             run;

  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  s2_idx;
  logic [IDX_W-1:0]  rfl_idx;
  logic [TAG_W-1:0]  rfl_tag;
  logic [WOFF_W-1:0] s2_word;
  logic              clr_en;
  logic [IDX_W-1:0]  clr_idx;
  logic [WAYS-1:0]   rfl_vld;
  logic [WAYS-1:0]   rfl_vict;
  logic [WAYS-1:0]   rfl_wr;
  logic              unused_ok;

  logic [PLRU_W-1:0] plru_q [SETS];

  // Tree layout: bit0 root (0 = left half), bit1 ways 0/1, bit2 ways 2/3
  function automatic int plru_way(input logic [PLRU_W-1:0] p);
    logic [2:0] t;
    t = 3'(p);
    if (WAYS == 2) return t[0] ? 1 : 0;
    return t[0] ? (t[2] ? 3 : 2) : (t[1] ? 1 : 0);
  endfunction

  function automatic logic [PLRU_W-1:0] plru_upd(
    input logic [PLRU_W-1:0] p,
    input int                w
  );
    logic [2:0] t;
    t = 3'(p);
    if (WAYS == 2) begin
      t[0] = (w == 0);
    end else if (w < 2) begin
      t[0] = 1'b1;
      t[1] = (w == 0);
    end else begin
      t[0] = 1'b0;
      t[2] = (w == 2);
    end
    return PLRU_W'(t);
  endfunction

  function automatic logic [WAYS-1:0] pick_victim(
    input logic [WAYS-1:0]   vld,
    input logic [PLRU_W-1:0] p
  );
    int              w;
    logic [WAYS-1:0] oh;
    w = plru_way(p);
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!vld[i]) w = i;
    end
    for (int i = 0; i < WAYS; i++) oh[i] = (i == w);
    return oh;
  endfunction

  function automatic int oh2way(input logic [WAYS-1:0] oh);
    int w;
    w = 0;
    for (int i = 0; i < WAYS; i++) begin
      if (oh[i]) w = i;
    end
    return w;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == IDX_W'(SETS - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  assign init_busy_o = (state_q == ST_INIT);
  assign run         = (state_q == ST_RUN);

  // Re-read the S2 set during a stall so the outputs hold
  assign rd_idx  = stall_i ? s2_vaddr_o[OFF_W +: IDX_W]
                           : vaddr_i[OFF_W +: IDX_W];
  assign s2_idx  = s2_vaddr_o[OFF_W +: IDX_W];
  assign s2_word = s2_vaddr_o[2 +: WOFF_W];
  assign rfl_idx = rfl_vaddr_i[OFF_W +: IDX_W];
  assign rfl_tag = rfl_paddr_i[ADDR_W-1 -: TAG_W];

  assign unused_ok = ^{rfl_vaddr_i, rfl_paddr_i};

  assign clr_en  = init_busy_o | (run & inv_valid_i);
  assign clr_idx = init_busy_o ? ptr_q : inv_index_i;

  assign rfl_vict    = pick_victim(rfl_vld, plru_q[rfl_idx]);
  assign s2_victim_o = pick_victim(s2_valid_o, plru_q[s2_idx]);

  // Refill update issued last so it wins over a same-set hit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else if (run) begin
      if (hit_valid_i)
        plru_q[s2_idx] <= plru_upd(plru_q[s2_idx], oh2way(hit_i));
      if (rfl_valid_i)
        plru_q[rfl_idx] <= plru_upd(plru_q[rfl_idx], oh2way(rfl_vict));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_vaddr_o   <= '0;
      s2_paddr_o   <= '0;
      s2_en_o      <= 1'b0;
      s2_rreq_o    <= 1'b0;
      s2_cached_o  <= 1'b0;
      s2_install_o <= 1'b0;
    end else begin
      s2_install_o <= stall_i;
      if (!stall_i) begin
        s2_vaddr_o  <= vaddr_i;
        s2_paddr_o  <= paddr_i;
        s2_en_o     <= req_i & ~init_busy_o;
        s2_rreq_o   <= req_i & cached_i & ~init_busy_o;
        s2_cached_o <= cached_i;
      end
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [LINE_WORDS-1:0][31:0] line;

    assign rfl_wr[w] = run & rfl_valid_i & rfl_vict[w];

    icache_way_ram #(
      .SETS       (SETS),
      .LINE_WORDS (LINE_WORDS),
      .TAG_W      (TAG_W),
      .IDX_W      (IDX_W)
    ) u_ram (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_idx     (rd_idx),
      .wr_en      (rfl_wr[w]),
      .wr_idx     (rfl_idx),
      .wr_tag     (rfl_tag),
      .wr_line    (rfl_line_i),
      .clr_en     (clr_en),
      .clr_idx    (clr_idx),
      .vld_idx    (rfl_idx),
      .vld_o      (rfl_vld[w]),
      .rd_tag_o   (s2_tag_o[w*TAG_W +: TAG_W]),
      .rd_valid_o (s2_valid_o[w]),
      .rd_line_o  (line)
    );

    assign s2_data_o[w*32 +: 32] = line[s2_word];
  end

endmodule
